// File: rtl/pixel_stream_gen.sv
// Raster pixel generator: streams one frame of BG_COLOR pixels with a 2x-scaled
// 16x16 masked sprite overlaid, one pixel per pixel_req pulse.
module pixel_stream_gen #(
  parameter int                    WIDTH       = 176,
  parameter int                    HEIGHT      = 220,
  parameter int                    PIXEL_SIZE  = 16,
  parameter logic [PIXEL_SIZE-1:0] BG_COLOR    = 16'h0000,
  parameter logic [255:0]          SPRITE_MASK = {256{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pixel_req,
  input  logic [7:0]            sprite_x,
  input  logic [7:0]            sprite_y,
  input  logic [15:0]           sprite_color,
  output logic [PIXEL_SIZE-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  frame_done,
  output logic                  busy
);

  // Handshake: frame_start and pixel_req are single-cycle pulses with no back-pressure.
  // A pixel_req accepted in STREAM yields exactly one pixel_valid pulse on the next
  // cycle; frame_start has priority and swallows a coincident pixel_req.

  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           x, y;
  logic [7:0]              spr_x, spr_y;
  logic [15:0]             spr_color;
  logic                    last_col, last_px, in_x, in_y, mask_bit;
  logic [3:0]              mask_row, mask_col;
  logic [PIXEL_SIZE-1:0]   pix_next;

  // Sprite hit test; coordinates widened so sx+32 never wraps.
  always_comb begin
    last_col = (x == CW'(WIDTH - 1));
    last_px  = last_col && (y == CW'(HEIGHT - 1));
    in_x     = (x >= CW'(spr_x)) && (x < CW'(spr_x) + CW'(32));
    in_y     = (y >= CW'(spr_y)) && (y < CW'(spr_y) + CW'(32));
    // floor((a - s) / 2) from the low bits: subtract halves, borrow when a even and s odd
    mask_col = x[4:1] - spr_x[4:1] - {3'b000, (~x[0] & spr_x[0])};
    mask_row = y[4:1] - spr_y[4:1] - {3'b000, (~y[0] & spr_y[0])};
    mask_bit = SPRITE_MASK[{mask_row, mask_col}];
    pix_next = (in_x && in_y && mask_bit) ? PIXEL_SIZE'(spr_color) : BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (frame_start) state_next = STREAM;
      STREAM: begin
        if (frame_start)                state_next = STREAM;
        else if (pixel_req && last_px)  state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == STREAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      spr_x       <= '0;
      spr_y       <= '0;
      spr_color   <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else if (frame_start) begin
      x           <= '0;
      y           <= '0;
      spr_x       <= sprite_x;
      spr_y       <= sprite_y;
      spr_color   <= sprite_color;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else if (state == STREAM && pixel_req) begin
      pixel_data  <= pix_next;
      pixel_valid <= 1'b1;
      if (last_px) begin
        frame_done <= 1'b1;
      end else if (last_col) begin
        x <= '0;
        y <= y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end else begin
      pixel_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen: spot-pixel tables per frame plus
// hand-written sequences for restart, reset and idle behaviour.
module tb_pixel_stream_gen;

  localparam int W    = 176;
  localparam int H    = 220;
  localparam int NPIX = W * H;
  localparam logic [255:0] MASK_A = {256{1'b1}};
  localparam logic [255:0] MASK_B = ~256'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixel_req = 1'b0;
  logic [7:0]  sprite_x = '0;
  logic [7:0]  sprite_y = '0;
  logic [15:0] sprite_color = '0;

  logic [15:0] a_data, b_data;
  logic        a_valid, a_done, a_busy;
  logic        b_valid, b_done, b_busy;

  always #5 clk = ~clk;

  pixel_stream_gen dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_req(pixel_req),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color),
    .pixel_data(a_data), .pixel_valid(a_valid), .frame_done(a_done), .busy(a_busy)
  );

  pixel_stream_gen #(.SPRITE_MASK(MASK_B)) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_req(pixel_req),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color),
    .pixel_data(b_data), .pixel_valid(b_valid), .frame_done(b_done), .busy(b_busy)
  );

  typedef struct {
    int          f;
    int          x;
    int          y;
    logic [15:0] ea;
    logic [15:0] eb;
  } spot_t;

  spot_t       spots[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] pix_a[NPIX];
  logic [15:0] pix_b[NPIX];
  int          cur_a = 0;
  int          cur_b = 0;
  int          fd_at = -1;
  logic        busy_last = 1'b1;
  int          cur_sx = 0;
  int          cur_sy = 0;
  logic [15:0] cur_col = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int x, input int y, input int sx, input int sy,
                                        input logic [15:0] col, input logic [255:0] mask);
    if (x >= sx && x < sx + 32 && y >= sy && y < sy + 32 && mask[((y - sy) / 2) * 16 + (x - sx) / 2])
      return col;
    return 16'h0000;
  endfunction

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pixel_req = 1'b1;
      @(posedge clk);
      #1;
      if (a_valid) begin
        if (cur_a < NPIX) pix_a[cur_a] = a_data;
        if (cur_a == NPIX - 1) busy_last = a_busy;
        cur_a++;
        if (a_done && fd_at < 0) fd_at = cur_a;
      end
      if (b_valid) begin
        if (cur_b < NPIX) pix_b[cur_b] = b_data;
        cur_b++;
      end
    end
    @(negedge clk) pixel_req = 1'b0;
  endtask

  task automatic start_frame(input int sx, input int sy, input logic [15:0] col, input bit with_req);
    @(negedge clk);
    sprite_x     = 8'(sx);
    sprite_y     = 8'(sy);
    sprite_color = col;
    frame_start  = 1'b1;
    pixel_req    = with_req;
    @(posedge clk);
    #1;
    check("fs_no_valid", {31'd0, a_valid}, 32'd0);
    check("fs_busy", {31'd0, a_busy}, 32'd1);
    check("fs_done_clear", {31'd0, a_done}, 32'd0);
    @(negedge clk);
    frame_start  = 1'b0;
    pixel_req    = 1'b0;
    sprite_x     = 8'hFF;
    sprite_y     = 8'hFF;
    sprite_color = 16'h5A5A;
    cur_a = 0; cur_b = 0; fd_at = -1; busy_last = 1'b1;
    cur_sx = sx; cur_sy = sy; cur_col = col;
  endtask

  task automatic compare_frame(input string name, input int n);
    int bad_a = 0;
    int bad_b = 0;
    for (int i = 0; i < n; i++) begin
      if (pix_a[i] !== model(i % W, i / W, cur_sx, cur_sy, cur_col, MASK_A)) bad_a++;
      if (pix_b[i] !== model(i % W, i / W, cur_sx, cur_sy, cur_col, MASK_B)) bad_b++;
    end
    check({name, "_a_bad_pixels"}, bad_a, 32'd0);
    check({name, "_b_bad_pixels"}, bad_b, 32'd0);
  endtask

  task automatic check_spots(input int f);
    foreach (spots[k]) begin
      if (spots[k].f == f) begin
        check($sformatf("f%0d_a(%0d,%0d)", f, spots[k].x, spots[k].y),
              {16'd0, pix_a[spots[k].y * W + spots[k].x]}, {16'd0, spots[k].ea});
        check($sformatf("f%0d_b(%0d,%0d)", f, spots[k].x, spots[k].y),
              {16'd0, pix_b[spots[k].y * W + spots[k].x]}, {16'd0, spots[k].eb});
      end
    end
  endtask

  task automatic full_frame(input string name, input int f, input int sx, input int sy,
                            input logic [15:0] col);
    start_frame(sx, sy, col, 1'b0);
    stream(NPIX + 4);
    check({name, "_count_a"}, cur_a, NPIX);
    check({name, "_count_b"}, cur_b, NPIX);
    check({name, "_done_at"}, fd_at, NPIX);
    check({name, "_busy_at_last"}, {31'd0, busy_last}, 32'd0);
    check({name, "_done_held"}, {31'd0, a_done}, 32'd1);
    check({name, "_busy_after"}, {31'd0, a_busy}, 32'd0);
    compare_frame(name, NPIX);
    check_spots(f);
  endtask

  initial begin
    spots = '{
      '{1, 0, 0, 16'hF800, 16'h0000},   '{1, 1, 1, 16'hF800, 16'h0000},
      '{1, 2, 0, 16'hF800, 16'hF800},   '{1, 31, 31, 16'hF800, 16'hF800},
      '{1, 32, 0, 16'h0000, 16'h0000},  '{1, 0, 32, 16'h0000, 16'h0000},
      '{1, 175, 219, 16'h0000, 16'h0000},
      '{2, 160, 210, 16'h07E0, 16'h0000}, '{2, 175, 219, 16'h07E0, 16'h07E0},
      '{2, 162, 212, 16'h07E0, 16'h07E0}, '{2, 159, 210, 16'h0000, 16'h0000},
      '{2, 0, 210, 16'h0000, 16'h0000},   '{2, 160, 0, 16'h0000, 16'h0000},
      '{2, 0, 0, 16'h0000, 16'h0000},
      '{3, 10, 10, 16'h001F, 16'h0000},   '{3, 11, 10, 16'h001F, 16'h0000},
      '{3, 10, 11, 16'h001F, 16'h0000},   '{3, 11, 11, 16'h001F, 16'h0000},
      '{3, 12, 10, 16'h001F, 16'h001F},   '{3, 9, 10, 16'h0000, 16'h0000}
    };

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {16'd0, a_data}, 32'd0);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Requests with no frame_start are ignored
    stream(10);
    check("idle_valids", cur_a, 32'd0);
    check("idle_data", {16'd0, a_data}, 32'd0);
    check("idle_busy", {31'd0, a_busy}, 32'd0);

    full_frame("f1", 1, 0, 0, 16'hF800);
    full_frame("f2", 2, 160, 210, 16'h07E0);

    // Masked corner, partial frame
    start_frame(10, 10, 16'h001F, 1'b0);
    stream(13 * W);
    check("f3_count_b", cur_b, 13 * W);
    compare_frame("f3", 13 * W);
    check_spots(3);

    // Restart mid-frame with a coincident pixel_req
    start_frame(10, 10, 16'h001F, 1'b0);
    stream(100);
    check("restart_pre_count", cur_a, 32'd100);
    start_frame(0, 0, 16'hABCD, 1'b1);
    stream(1);
    check("restart_count", cur_a, 32'd1);
    check("restart_first_a", {16'd0, pix_a[0]}, 32'h0000ABCD);
    check("restart_first_b", {16'd0, pix_b[0]}, 32'h00000000);

    // Asynchronous reset in the middle of a frame
    stream(529);
    check("pre_rst_count", cur_a, 32'd530);
    @(negedge clk) pixel_req = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, a_valid}, 32'd1);
    check("pre_rst_data", {16'd0, a_data}, 32'h0000ABCD);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, a_valid}, 32'd0);
    check("async_rst_data", {16'd0, a_data}, 32'd0);
    check("async_rst_busy", {31'd0, a_busy}, 32'd0);
    check("async_rst_done", {31'd0, a_done}, 32'd0);
    @(negedge clk) pixel_req = 1'b0;
    @(negedge clk) rst = 1'b0;
    cur_a = 0; cur_b = 0;
    stream(5);
    check("post_rst_valids", cur_a, 32'd0);
    start_frame(5, 0, 16'h1234, 1'b0);
    stream(8);
    check("post_rst_a(0,0)", {16'd0, pix_a[0]}, 32'h00000000);
    check("post_rst_a(5,0)", {16'd0, pix_a[5]}, 32'h00001234);
    check("post_rst_b(5,0)", {16'd0, pix_b[5]}, 32'h00000000);
    check("post_rst_b(7,0)", {16'd0, pix_b[7]}, 32'h00001234);
    compare_frame("post_rst", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
